// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register that feeds the 16-bit ALU.
// Captures decoded instructions over a valid/ready handshake, resolves RAW
// hazards by forwarding from EX/MEM and MEM/WB, and counts back-pressure cycles.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready, in_*        decoded instruction from decode
//   flush                          kill the held instruction (branch redirect)
//   fwd_mem_*, fwd_wb_*            forwarding sources (EX/MEM, MEM/WB)
//   out_valid/out_ready            handshake to the memory/writeback stages
//   alu_a, alu_b, alu_op           ALU operand and opcode drive
//   out_rd_addr, out_reg_we        destination info, qualified by out_valid
//   stall_cnt                      saturating count of back-pressured cycles
module ex_operand_stage #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_ADDR_W-1:0]  in_rs_addr,
    input  logic [REG_ADDR_W-1:0]  in_rt_addr,
    input  logic [DATA_WIDTH-1:0]  in_rs_data,
    input  logic [DATA_WIDTH-1:0]  in_rt_data,
    input  logic [DATA_WIDTH-1:0]  in_imm,
    input  logic                   in_use_imm,
    input  logic [1:0]             in_alu_op,
    input  logic [REG_ADDR_W-1:0]  in_rd_addr,
    input  logic                   in_reg_we,
    input  logic                   flush,
    input  logic                   fwd_mem_we,
    input  logic [REG_ADDR_W-1:0]  fwd_mem_addr,
    input  logic [DATA_WIDTH-1:0]  fwd_mem_data,
    input  logic                   fwd_wb_we,
    input  logic [REG_ADDR_W-1:0]  fwd_wb_addr,
    input  logic [DATA_WIDTH-1:0]  fwd_wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    output logic [1:0]             alu_op,
    output logic [REG_ADDR_W-1:0]  out_rd_addr,
    output logic                   out_reg_we,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Held instruction state
    logic [REG_ADDR_W-1:0] rs_addr_q;
    logic [REG_ADDR_W-1:0] rt_addr_q;
    logic [DATA_WIDTH-1:0] rs_data_q;
    logic [DATA_WIDTH-1:0] rt_data_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  use_imm_q;
    logic [1:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic                  reg_we_q;

    logic                  load;
    logic                  hold;
    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;

    // EX/MEM has priority over MEM/WB; register 0 is hard-wired and never forwarded
    function automatic logic [DATA_WIDTH-1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] src,
        input logic [DATA_WIDTH-1:0] held,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_addr,
        input logic [DATA_WIDTH-1:0] mem_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_addr,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        logic [DATA_WIDTH-1:0] val;
        val = held;
        if (src != '0) begin
            if (mem_we && (mem_addr == src)) begin
                val = mem_data;
            end else if (wb_we && (wb_addr == src)) begin
                val = wb_data;
            end
        end
        return val;
    endfunction

    // Handshake: no bubble, a draining slot can be refilled in the same cycle
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign hold     = out_valid && !out_ready;

    // Operand forwarding and ALU drive
    always_comb begin
        rs_fwd = fwd_select(rs_addr_q, rs_data_q, fwd_mem_we, fwd_mem_addr, fwd_mem_data,
                            fwd_wb_we, fwd_wb_addr, fwd_wb_data);
        rt_fwd = fwd_select(rt_addr_q, rt_data_q, fwd_mem_we, fwd_mem_addr, fwd_mem_data,
                            fwd_wb_we, fwd_wb_addr, fwd_wb_data);
    end

    assign alu_a       = rs_fwd;
    assign alu_b       = use_imm_q ? imm_q : rt_fwd;
    assign alu_op      = op_q;
    assign out_rd_addr = rd_addr_q;
    assign out_reg_we  = reg_we_q;

    // Pipeline register, hold refresh and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            op_q      <= '0;
            rd_addr_q <= '0;
            reg_we_q  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (load) begin
                rs_addr_q <= in_rs_addr;
                rt_addr_q <= in_rt_addr;
                rs_data_q <= in_rs_data;
                rt_data_q <= in_rt_data;
                imm_q     <= in_imm;
                use_imm_q <= in_use_imm;
                op_q      <= in_alu_op;
                rd_addr_q <= in_rd_addr;
                reg_we_q  <= in_reg_we;
            end else if (hold) begin
                // Latch forwarded values so they survive the producer retiring
                rs_data_q <= rs_fwd;
                rt_data_q <= rt_fwd;
            end

            if (hold && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the 16-bit ALU and drives its a, b and alu_op inputs.
- Accepts decoded instructions from decode over a valid/ready handshake and registers operands, immediate select and destination info.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and hands off to the memory/writeback stages with valid/ready.
- Provides a saturating back-pressure stall counter for performance debug.

Parameters:
- DATA_WIDTH, 16, operand/result width; matches the ALU.
- REG_ADDR_W, 3, register-address width (8 architectural registers).
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode has an instruction.
- in_ready  out  1  stage can accept.
- in_rs_addr  in  REG_ADDR_W  source A register.
- in_rt_addr  in  REG_ADDR_W  source B register.
- in_rs_data  in  DATA_WIDTH  register-file value for rs.
- in_rt_data  in  DATA_WIDTH  register-file value for rt.
- in_imm  in  DATA_WIDTH  pre-extended immediate.
- in_use_imm  in  1  1: B operand = immediate.
- in_alu_op  in  2  00 add, 01 xor, 10 pass B, 11 sub.
- in_rd_addr  in  REG_ADDR_W  destination register.
- in_reg_we  in  1  instruction writes rd.
- flush  in  1  kill the held instruction (branch redirect).
- fwd_mem_we  in  1  EX/MEM result valid for forwarding.
- fwd_mem_addr  in  REG_ADDR_W  EX/MEM destination.
- fwd_mem_data  in  DATA_WIDTH  EX/MEM result.
- fwd_wb_we  in  1  MEM/WB result valid for forwarding.
- fwd_wb_addr  in  REG_ADDR_W  MEM/WB destination.
- fwd_wb_data  in  DATA_WIDTH  MEM/WB result.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts.
- alu_a  out  DATA_WIDTH  to ALU a.
- alu_b  out  DATA_WIDTH  to ALU b.
- alu_op  out  2  to ALU alu_op.
- out_rd_addr  out  REG_ADDR_W  destination register.
- out_reg_we  out  1  write-enable (qualified by out_valid).
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n low, async): out_valid=0; held rs/rt/imm data, rd_addr, reg_we, use_imm and alu_op are cleared to 0; stall_cnt=0. With these values alu_a=alu_b=0 and alu_op=00.
- in_ready = !out_valid || out_ready. This is combinational with no bubble, so one instruction per cycle is sustained at full throughput.
- Load: when in_valid && in_ready && !flush, all in_* fields are captured and out_valid=1 on the next edge. Latency is 1 cycle from acceptance to operands at the ALU.
- Drain: when out_valid && out_ready and nothing is loaded, out_valid=0 on the next edge.
- Flush: out_valid=0 on the next edge and the input is not accepted that cycle, whatever the handshake state. Flush has priority over load and over hold.
- Forwarding (combinational on outputs), per source operand s in {rs, rt}:
  - if fwd_mem_we && fwd_mem_addr==s && s!=0, use fwd_mem_data;
  - else if fwd_wb_we && fwd_wb_addr==s && s!=0, use fwd_wb_data;
  - else use the held register-file data.
  - EX/MEM wins when both sources match.
  - Register 0 is never forwarded.
- alu_a is the forwarded rs value. alu_b is the held immediate if use_imm=1; otherwise it is the forwarded rt value.
- Hold refresh: while out_valid && !out_ready, each edge writes the forwarded rs/rt values back into the held data registers. This keeps a forwarded value after its producer retires. The immediate is never refreshed.
- alu_op, out_rd_addr and out_reg_we come straight from held registers. Downstream qualifies them with out_valid.
- stall_cnt increments on every edge with out_valid && !out_ready. It saturates at all-ones and is cleared only by reset.
- Simultaneous drain and load in the same cycle: the new instruction replaces the old one and out_valid stays 1.
- rst_n asserted mid-stall drops the held instruction immediately. in_ready=1 after release.

Test Plan:
- Reset, then accept {rs=1 data 0x0005, rt=2 data 0x0003, op=11, rd=3} with out_ready=1, no forwarding -> next cycle out_valid=1, alu_a=0x0005, alu_b=0x0003, alu_op=11, out_rd_addr=3.
- Held rs=4 with fwd_mem {we=1, addr 4, 0x1234} and fwd_wb {we=1, addr 4, 0xBEEF} -> alu_a=0x1234. The same case with rs=0 -> alu_a = held data (0x0000 path), no forward.
- in_use_imm=1, imm=0xFFF0, rt=2 matching fwd_wb 0x7777 -> alu_b=0xFFF0.
- Hold out_ready=0 for 3 cycles with fwd_wb {addr 1, 0x00AA} on cycle 1 only, held rs=1 -> alu_a stays 0x00AA on cycles 2-3, in_ready=0 throughout, stall_cnt=3.
- Back-to-back stream of 4 instructions with out_ready=1 -> 4 transfers in 4 consecutive cycles with no bubble. Assert flush on the 3rd -> out_valid=0 the following cycle and the in_* word presented on the flush cycle is not captured.
- Preload stall_cnt to 0xFFFF via a long stall -> remains 0xFFFF. Pulse rst_n low while out_valid=1 -> out_valid, alu_a and alu_b drop to 0 asynchronously.
